ram_arbiter: RTL and testbench

//  Shares one single-port RAM between two requesters (port A, port B) using valid/ready handshakes.

---
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two valid/ready requesters sharing one single-port RAM.
// Round-robin with bounded bursts, registered command, tagged read return.
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  owner_t           owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_b;
  logic             hit;
  logic             grant_a;
  logic             grant_b;
  logic             accept;
  logic             same;
  logic             other_valid;
  logic             win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic             t1_valid;
  logic             t1_b;
  logic             t2_valid;
  logic             t2_b;

  assign hit = (burst_cnt == CNT_LAST);

  // Priority: continuing burst, forced hand-over, then round-robin.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!sys_rst) begin
      if (owner == OWN_A && a_valid && !hit) begin
        grant_a = 1'b1;
      end else if (owner == OWN_B && b_valid && !hit) begin
        grant_b = 1'b1;
      end else if (owner == OWN_A && hit && b_valid) begin
        grant_b = 1'b1;
      end else if (owner == OWN_B && hit && a_valid) begin
        grant_a = 1'b1;
      end else if (a_valid && b_valid) begin
        grant_a = last_b;
        grant_b = !last_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign accept      = grant_a | grant_b;
  assign same        = (owner == OWN_A && grant_a) ||
                       (owner == OWN_B && grant_b);
  assign other_valid = grant_b ? a_valid : b_valid;
  assign win_we      = grant_b ? b_we    : a_we;
  assign win_addr    = grant_b ? b_addr  : a_addr;
  assign win_wdata   = grant_b ? b_wdata : a_wdata;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      owner     <= OWN_NONE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      t1_valid  <= 1'b0;
      t1_b      <= 1'b0;
      t2_valid  <= 1'b0;
      t2_b      <= 1'b0;
    end else begin
      t2_valid <= t1_valid;
      t2_b     <= t1_b;
      t1_valid <= accept & !win_we;
      t1_b     <= grant_b;
      ram_en   <= accept;
      ram_we   <= accept & win_we;
      if (accept) begin
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
        last_b    <= grant_b;
        if (same) begin
          // a lone requester keeps restarting its burst
          burst_cnt <= other_valid ? burst_cnt + 1'b1 : '0;
        end else begin
          owner     <= grant_b ? OWN_B : OWN_A;
          burst_cnt <= '0;
        end
      end else begin
        owner     <= OWN_NONE;
        burst_cnt <= '0;
      end
    end
  end

  assign a_rvalid = t2_valid & !t2_b;
  assign b_rvalid = t2_valid & t2_b;
  assign a_rdata  = a_rvalid ? ram_rdata : '0;
  assign b_rdata  = b_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter at MAX_BURST=4 and MAX_BURST=1 side by side:
// vector table, directed corners and random traffic against a model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, a_we = 1'b0;
  logic b_valid = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0;
  logic [7:0] b_addr = '0, b_wdata = '0;
  logic [1:0] a_ready, a_rvalid, b_ready, b_rvalid;
  logic [1:0] ram_en, ram_we;
  logic [7:0] a_rdata [2];
  logic [7:0] b_rdata [2];
  logic [7:0] ram_addr [2];
  logic [7:0] ram_wdata [2];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gd
    logic [7:0] mem [256];
    logic [7:0] rd = 8'h00;
    ram_arbiter #(
      .ADDR_W(8), .DATA_W(8), .MAX_BURST(g == 0 ? 4 : 1)
    ) dut (
      .sys_clk(clk), .sys_rst(rst),
      .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_ready(a_ready[g]),
      .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]),
      .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_ready(b_ready[g]),
      .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]),
      .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
      .ram_rdata(rd)
    );
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk)
      if (ram_en[g]) begin
        if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
        else rd <= mem[ram_addr[g]];
      end
  end

  // reference model: owner -1/0/1, streak = accepts in current run
  int mb [2] = '{4, 1};
  int own [2];
  int streak [2];
  int last [2];
  bit c_en [2], c_we [2];
  logic [7:0] c_addr [2], c_wd [2];
  bit p1v [2], p1b [2], p2v [2], p2b [2];
  logic [7:0] p1d [2], p2d [2];
  logic [7:0] mm [2][256];

  function automatic int pick(int k, bit av, bit bv);
    if (av && bv) begin
      if (own[k] < 0) return 1 - last[k];
      if (streak[k] < mb[k]) return own[k];
      return 1 - own[k];
    end
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  task automatic model_reset(int k);
    own[k] = -1; streak[k] = 0; last[k] = 1;
    c_en[k] = 0; c_we[k] = 0; c_addr[k] = '0; c_wd[k] = '0;
    p1v[k] = 0; p1b[k] = 0; p1d[k] = '0;
    p2v[k] = 0; p2b[k] = 0; p2d[k] = '0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(bit r, bit av, bit awe, logic [7:0] aad,
                      logic [7:0] awd, bit bv, bit bwe,
                      logic [7:0] bad, logic [7:0] bwd);
    int w;
    bit we;
    logic [7:0] ad, wd;
    @(negedge clk);
    rst = r;
    a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      w = r ? -1 : pick(k, av, bv);
      chk($sformatf("d%0d a_ready", k), 32'(a_ready[k]), 32'(w == 0));
      chk($sformatf("d%0d b_ready", k), 32'(b_ready[k]), 32'(w == 1));
      chk($sformatf("d%0d ram_en", k), 32'(ram_en[k]), 32'(c_en[k]));
      chk($sformatf("d%0d ram_we", k), 32'(ram_we[k]), 32'(c_we[k]));
      chk($sformatf("d%0d ram_addr", k), 32'(ram_addr[k]), 32'(c_addr[k]));
      chk($sformatf("d%0d ram_wdata", k), 32'(ram_wdata[k]), 32'(c_wd[k]));
      chk($sformatf("d%0d a_rvalid", k), 32'(a_rvalid[k]),
          32'(p2v[k] && !p2b[k]));
      chk($sformatf("d%0d a_rdata", k), 32'(a_rdata[k]),
          32'((p2v[k] && !p2b[k]) ? p2d[k] : 8'h00));
      chk($sformatf("d%0d b_rvalid", k), 32'(b_rvalid[k]),
          32'(p2v[k] && p2b[k]));
      chk($sformatf("d%0d b_rdata", k), 32'(b_rdata[k]),
          32'((p2v[k] && p2b[k]) ? p2d[k] : 8'h00));
      if (r) begin
        model_reset(k);
      end else begin
        p2v[k] = p1v[k]; p2b[k] = p1b[k]; p2d[k] = p1d[k];
        p1v[k] = 0;
        c_en[k] = (w >= 0);
        c_we[k] = 0;
        if (w >= 0) begin
          we = (w == 1) ? bwe : awe;
          ad = (w == 1) ? bad : aad;
          wd = (w == 1) ? bwd : awd;
          c_we[k] = we; c_addr[k] = ad; c_wd[k] = wd;
          if (we) mm[k][ad] = wd;
          else begin
            p1v[k] = 1; p1b[k] = (w == 1); p1d[k] = mm[k][ad];
          end
          if (w == own[k])
            streak[k] = ((w == 0) ? bv : av) ? streak[k] + 1 : 1;
          else begin
            own[k] = w; streak[k] = 1;
          end
          last[k] = w;
        end else begin
          own[k] = -1; streak[k] = 0;
        end
      end
    end
  endtask

  typedef struct {
    bit av, bv, we;
    bit ga0, gb0, ga1, gb1;
  } vec_t;

  initial begin
    vec_t vec [20];
    string s0, s1;
    int cnt_br, cnt_bv, cnt_av, run, max_run, pa, pb;
    bit r;

    s0 = "AAAABBBBAAAAAAAAAABB";
    s1 = "ABABABABABAAAAABABAB";
    for (int i = 0; i < 20; i++) begin
      vec[i].av = 1'b1;
      vec[i].bv = !(i >= 10 && i < 15);
      vec[i].we = (i < 10);
      vec[i].ga0 = (s0[i] == "A");
      vec[i].gb0 = (s0[i] == "B");
      vec[i].ga1 = (s1[i] == "A");
      vec[i].gb1 = (s1[i] == "B");
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mm[k][i] = 8'h00;
      model_reset(k);
    end

    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // arbitration order, starting with a tie right after reset
    for (int i = 0; i < 20; i++) begin
      step(0, vec[i].av, vec[i].we, 8'(i % 10), 8'(i * 3 + 1),
           vec[i].bv, vec[i].we, 8'(16 + i % 10), 8'(i * 5 + 2));
      chk("tbl d0 a_ready", 32'(a_ready[0]), 32'(vec[i].ga0));
      chk("tbl d0 b_ready", 32'(b_ready[0]), 32'(vec[i].gb0));
      chk("tbl d1 a_ready", 32'(a_ready[1]), 32'(vec[i].ga1));
      chk("tbl d1 b_ready", 32'(b_ready[1]), 32'(vec[i].gb1));
    end

    // write then read the same address from A
    step(0, 1, 1, 8'h05, 8'h5A, 0, 0, 0, 0);
    step(0, 1, 0, 8'h05, 8'h00, 0, 0, 0, 0);
    chk("wr cmd en", 32'(ram_en[0]), 32'd1);
    chk("wr cmd we", 32'(ram_we[0]), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd cmd en", 32'(ram_en[0]), 32'd1);
    chk("rd cmd we", 32'(ram_we[0]), 32'd0);
    chk("rd cmd addr", 32'(ram_addr[0]), 32'h05);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd ret valid", 32'(a_rvalid[0]), 32'd1);
    chk("rd ret data", 32'(a_rdata[0]), 32'h5A);

    // lone B streams ten reads
    cnt_br = 0; cnt_bv = 0; cnt_av = 0; run = 0; max_run = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) step(0, 0, 0, 0, 0, 1, 0, 8'(i), 0);
      else step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cnt_br += int'(b_ready[0]);
      cnt_bv += int'(b_rvalid[0]);
      cnt_av += int'(a_rvalid[0]);
      run = b_rvalid[0] ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("lone b ready", 32'(cnt_br), 32'd10);
    chk("lone b rvalid", 32'(cnt_bv), 32'd10);
    chk("lone b run", 32'(max_run), 32'd10);
    chk("lone b no a", 32'(cnt_av), 32'd0);

    // reset right after a read accept drops the return
    cnt_av = 0;
    step(0, 1, 0, 8'h05, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cnt_av += int'(a_rvalid[0]);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cnt_av += int'(a_rvalid[0]);
    chk("rst ram_en", 32'(ram_en[0]), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cnt_av += int'(a_rvalid[0]);
    chk("rst no rvalid", 32'(cnt_av), 32'd0);

    for (int i = 0; i < 600; i++) begin
      unique case (i / 150)
        0: begin pa = 95; pb = 95; end
        1: begin pa = 30; pb = 30; end
        2: begin pa = 90; pb = 20; end
        default: begin pa = 60; pb = 80; end
      endcase
      r = ($urandom_range(0, 199) == 0);
      step(r, ($urandom_range(0, 99) < pa), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 8'($urandom),
           ($urandom_range(0, 99) < pb), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 8'($urandom));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
